// File: rtl/mult_pipe_stream.sv
// mult_pipe_stream: pipelined signed/unsigned multiplier with valid/ready handshake and tag sideband
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_signed/multiplicand/multiplier/in_tag (operand beat);
//        out_valid/out_ready/product/out_tag (result beat); busy = any stage holds a valid op.
module mult_pipe_stream #(
  parameter int WIDTH = 8,
  parameter int LATENCY = 3,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);
  localparam int L = LATENCY;
  localparam int PW = 2 * WIDTH;
  logic [L-1:0] v_q, v_d;
  logic [L-2:0] mv;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic s_q, s_d;
  logic [TAG_W-1:0] t0_q, t0_d;
  logic [L-1:1][PW-1:0] p_q, p_d;
  logic [L-1:1][TAG_W-1:0] t_q, t_d;
  logic [PW-1:0] ax, bx, mul;
  // Stage k advances when the output is taken or any later stage has a hole to collapse into.
  always_comb begin
    for (int k = 0; k < L - 1; k++) mv[k] = out_ready | ~&(v_q | ({L{1'b1}} >> (L - 1 - k)));
    in_ready = ~rst & (~v_q[0] | mv[0]);
    ax = s_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    bx = s_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    mul = ax * bx;
    v_d = v_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    t0_d = t0_q;
    p_d = p_q;
    t_d = t_q;
    if (in_ready) begin
      v_d[0] = in_valid;
      a_d = multiplicand;
      b_d = multiplier;
      s_d = in_signed;
      t0_d = in_tag;
    end
    if (mv[0]) begin
      v_d[1] = v_q[0];
      p_d[1] = mul;
      t_d[1] = t0_q;
    end
    for (int k = 1; k < L - 1; k++)
      if (mv[k]) begin
        v_d[k+1] = v_q[k];
        p_d[k+1] = p_q[k];
        t_d[k+1] = t_q[k];
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= 1'b0;
      t0_q <= '0;
      p_q <= '0;
      t_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      t0_q <= t0_d;
      p_q <= p_d;
      t_q <= t_d;
    end
  assign out_valid = v_q[L-1];
  assign product = p_q[L-1];
  assign out_tag = t_q[L-1];
  assign busy = |v_q;
endmodule

// File: tb/tb_mult_pipe_stream.sv
// tb_mult_pipe_stream: randomized and directed checks of mult_pipe_stream against a queue-based arithmetic model
module tb_mult_pipe_stream;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [7:0] multiplicand, multiplier;
  logic [3:0] in_tag, out_tag;
  logic [15:0] product;
  int vectors = 0;
  int errors = 0;
  bit acc, ohs, have;
  logic [19:0] exp_e, got_e;
  logic [19:0] q[$];

  mult_pipe_stream #(.WIDTH(8), .LATENCY(3), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .multiplicand(multiplicand), .multiplier(multiplier), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] model(bit s, logic [7:0] a, logic [7:0] b, logic [3:0] t);
    int x = s ? int'($signed(a)) : int'(a);
    int y = s ? int'($signed(b)) : int'(b);
    int p = x * y;
    return {p[15:0], t};
  endfunction

  task automatic set_rand();
    in_signed = 1'($urandom_range(0, 1));
    multiplicand = 8'($urandom);
    multiplier = 8'($urandom);
    in_tag = 4'($urandom);
  endtask

  // Called at posedge+1 with inputs set; observes the handshakes of the coming edge, then advances one cycle.
  task automatic tick();
    #1;
    acc = in_valid && in_ready;
    ohs = out_valid && out_ready;
    have = 1'b0;
    if (acc) q.push_back(model(in_signed, multiplicand, multiplier, in_tag));
    if (ohs) begin
      have = q.size() > 0;
      exp_e = '1;
      if (have) exp_e = q.pop_front();
      got_e = {product, out_tag};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    set_rand();
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h want 0000", product); end
    vectors++;
    if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_directed();
    bit s_t[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] a_t[6] = '{8'hFF, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00};
    logic [7:0] b_t[6] = '{8'hFF, 8'h80, 8'h01, 8'h01, 8'hB7, 8'h9C};
    logic [15:0] p_t[6] = '{16'hFE01, 16'h4000, 16'hFFFF, 16'h00FF, 16'h0000, 16'h0000};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_signed = s_t[i];
      multiplicand = a_t[i];
      multiplier = b_t[i];
      in_tag = 4'(i + 5);
      tick();
      vectors++;
      if (!acc) begin errors++; $display("FAIL directed_accept[%0d]: got 0 want 1", i); end
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      vectors++;
      if (lat != 3) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat); end
      vectors++;
      if ({product, out_tag} !== {p_t[i], 4'(i + 5)})
        begin errors++; $display("FAIL directed_product[%0d]: got %h/%h want %h/%h", i, product, out_tag, p_t[i], 4'(i + 5)); end
      tick();
      vectors++;
      if (!ohs || !have || got_e !== exp_e)
        begin errors++; $display("FAIL directed_model[%0d]: got %h want %h", i, got_e, exp_e); end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int first = -1;
    int last = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_valid = i < 16;
      if (i < 16) set_rand();
      tick();
      if (i < 16) begin
        vectors++;
        if (!acc) begin errors++; $display("FAIL b2b_in_ready[%0d]: got 0 want 1", i); end
      end
      if (ohs) begin
        vectors++;
        if (!have || got_e !== exp_e) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, got_e, exp_e); end
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    vectors++;
    if (n != 16 || last - first + 1 != 16)
      begin errors++; $display("FAIL b2b_throughput: got %0d results over %0d cycles want 16 over 16", n, last - first + 1); end
  endtask

  task automatic test_stall();
    int nacc = 0;
    logic [19:0] hold = '0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    set_rand();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acc) begin nacc++; set_rand(); end
      if (i == 2) begin
        hold = {product, out_tag};
        vectors++;
        if (!out_valid || hold !== q[0]) begin errors++; $display("FAIL stall_head: got %h want %h", hold, q[0]); end
      end
      if (i > 2) begin
        vectors++;
        if (!out_valid || {product, out_tag} !== hold)
          begin errors++; $display("FAIL stall_stable[%0d]: got %b/%h want 1/%h", i, out_valid, {product, out_tag}, hold); end
      end
    end
    vectors++;
    if (nacc != 3) begin errors++; $display("FAIL stall_accepts: got %0d want 3", nacc); end
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (!acc || !ohs) begin errors++; $display("FAIL full_handshake[%0d]: got acc=%b out=%b want 1/1", i, acc, ohs); end
      if (ohs) begin
        vectors++;
        if (!have || got_e !== exp_e) begin errors++; $display("FAIL full_result[%0d]: got %h want %h", i, got_e, exp_e); end
      end
      if (acc) set_rand();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ohs) begin
        vectors++;
        if (!have || got_e !== exp_e) begin errors++; $display("FAIL stall_drain[%0d]: got %h want %h", i, got_e, exp_e); end
      end
    end
    vectors++;
    if (q.size() != 0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL stall_empty: got %0d pending/out_valid=%b want 0/0", q.size(), out_valid); end
  endtask

  task automatic test_bubble();
    bit iv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit ea[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = iv[i];
      if (iv[i]) set_rand();
      tick();
      vectors++;
      if (acc !== ea[i]) begin errors++; $display("FAIL bubble_accept[%0d]: got %b want %b", i, acc, ea[i]); end
    end
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0)
      begin errors++; $display("FAIL bubble_flags: got busy=%b ov=%b ir=%b want 1/1/0", busy, out_valid, in_ready); end
    vectors++;
    if ({product, out_tag} !== q[0]) begin errors++; $display("FAIL bubble_head: got %h want %h", {product, out_tag}, q[0]); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ohs) begin
        vectors++;
        if (!have || got_e !== exp_e) begin errors++; $display("FAIL bubble_drain[%0d]: got %h want %h", i, got_e, exp_e); end
      end
    end
    vectors++;
    if (q.size() != 0) begin errors++; $display("FAIL bubble_empty: got %0d pending want 0", q.size()); end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      tick();
    end
    rst = 1'b1;
    set_rand();
    tick();
    vectors++;
    if (acc) begin errors++; $display("FAIL flush_accept_in_reset: got 1 want 0"); end
    rst = 1'b0;
    in_valid = 1'b0;
    q.delete();
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0 || out_tag !== 4'h0)
      begin errors++; $display("FAIL flush_state: got ov=%b busy=%b p=%h t=%h want 0", out_valid, busy, product, out_tag); end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (ohs) begin errors++; $display("FAIL flush_ghost[%0d]: got result %h want none", i, got_e); end
    end
    in_valid = 1'b1;
    set_rand();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ohs) begin
        vectors++;
        if (!have || got_e !== exp_e) begin errors++; $display("FAIL flush_after[%0d]: got %h want %h", i, got_e, exp_e); end
      end
    end
    vectors++;
    if (q.size() != 0) begin errors++; $display("FAIL flush_after_empty: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
